seq_binary_to_bcd: RTL and testbench

//   Iterative (shift-and-add-3) binary-to-BCD converter with start/done handshake.

---
 rtl/seq_binary_to_bcd.sv | 90 +++++++++
 tb/tb_seq_binary_to_bcd.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_binary_to_bcd.sv
// seq_binary_to_bcd: iterative shift-and-add-3 binary-to-BCD converter with start/done handshake.
// Optional BCD_BLANK_EN adds the registered leading-zero blanking output digit_blank.
module seq_binary_to_bcd #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     digit_blank
`endif
);
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t               state;
    logic [BIN_WIDTH-1:0] shift;
    logic [BW-1:0]        digits, adj, digits_next;
    logic [CW-1:0]        count;
    logic                 ovf, ovf_next;
    always_comb begin
        adj = digits;
        for (int k = 0; k < DIGITS; k++)
            adj[4*k +: 4] = digits[4*k +: 4] >= 4'd5 ? digits[4*k +: 4] + 4'd3 : digits[4*k +: 4];
    end
    // The bit leaving the top digit means the value no longer fits; it stays sticky.
    assign digits_next = {adj[BW-2:0], shift[BIN_WIDTH-1]};
    assign ovf_next    = ovf | adj[BW-1];
    assign busy        = state == SHIFT;
`ifdef BCD_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;
    logic [DIGITS-1:0] blank_next;
    logic              zero_above;
    always_comb begin
        blank_next = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above    = zero_above & (digits_next[4*k +: 4] == 4'd0);
            blank_next[k] = zero_above & ~ovf_next;
        end
    end
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            digits   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
`ifdef BCD_BLANK_EN
            digit_blank <= BLANK_RST;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    shift  <= binary;
                    digits <= '0;
                    ovf    <= 1'b0;
                    count  <= CW'(BIN_WIDTH);
                    state  <= SHIFT;
                end
            end else begin
                shift  <= shift << 1;
                digits <= digits_next;
                ovf    <= ovf_next;
                count  <= count - CW'(1);
                if (count == CW'(1)) begin
                    bcd      <= ovf_next ? {DIGITS{4'h9}} : digits_next;
                    overflow <= ovf_next;
                    done     <= 1'b1;
                    state    <= IDLE;
`ifdef BCD_BLANK_EN
                    digit_blank <= blank_next;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// tb_seq_binary_to_bcd: scoreboard bench for the default 8-bit/3-digit converter plus a 10-bit instance.
module tb_seq_binary_to_bcd;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, start10 = 1'b0;
    logic [7:0]  binary = '0;
    logic [9:0]  binary10 = '0;
    logic        busy, done, overflow, busy10, done10, overflow10;
    logic [11:0] bcd, bcd10;
    logic [12:0] q[$];
    logic [12:0] exp_v;
    int          total = 0, bad = 0;
`ifdef BCD_BLANK_EN
    logic [2:0]  digit_blank, digit_blank10;
`endif

    always #5 clk = ~clk;

    seq_binary_to_bcd #(.BIN_WIDTH(8), .DIGITS(3)) u_dut (
        .clk(clk), .reset(reset), .start(start), .binary(binary),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
`ifdef BCD_BLANK_EN
        , .digit_blank(digit_blank)
`endif
    );

    seq_binary_to_bcd #(.BIN_WIDTH(10), .DIGITS(3)) u_dut10 (
        .clk(clk), .reset(reset), .start(start10), .binary(binary10),
        .busy(busy10), .done(done10), .bcd(bcd10), .overflow(overflow10)
`ifdef BCD_BLANK_EN
        , .digit_blank(digit_blank10)
`endif
    );

    function automatic logic [12:0] model(input int v);
        if (v > 999) return {1'b1, 12'h999};
        return {1'b0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] blank_model(input logic [12:0] e);
        if (e[12]) return 3'b000;
        return {e[11:8] == 4'd0, e[11:4] == 8'd0, 1'b0};
    endfunction

    task automatic kick(input logic [7:0] v);
        @(negedge clk);
        binary = v;
        start  = 1'b1;
        q.push_back(model(int'(v)));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (busy && !done) busy_cnt++;
        end
    endtask

    task automatic test_reset;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (bcd !== 12'h000) begin bad++; $display("FAIL reset_bcd got=%h want=000", bcd); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
`ifdef BCD_BLANK_EN
        total++; if (digit_blank !== 3'b110) begin bad++; $display("FAIL reset_blank got=%b want=110", digit_blank); end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int cyc, bc;
        kick(8'd255);
        wait_done(cyc, bc);
        total++; if (done !== 1'b1 || cyc != 8) begin bad++; $display("FAIL lat255 got done=%b cyc=%0d want done=1 cyc=8", done, cyc); end
        total++; if (bc != 8) begin bad++; $display("FAIL busy_cycles got=%0d want=8", bc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_at_done got=%b want=0", busy); end
        exp_v = q.pop_front();
        total++; if ({overflow, bcd} !== exp_v) begin bad++; $display("FAIL val255 got=%b_%h want=%b_%h", overflow, bcd, exp_v[12], exp_v[11:0]); end
        @(negedge clk);
        total++; if (done !== 1'b0 || bcd !== exp_v[11:0]) begin bad++; $display("FAIL done_pulse got done=%b bcd=%h want done=0 bcd=%h", done, bcd, exp_v[11:0]); end
    endtask

    task automatic test_values;
        int cyc, bc;
        logic [7:0] vals[4] = '{8'd0, 8'd9, 8'd100, 8'd58};
        foreach (vals[i]) begin
            kick(vals[i]);
            wait_done(cyc, bc);
            exp_v = q.pop_front();
            total++; if (done !== 1'b1 || {overflow, bcd} !== exp_v) begin bad++; $display("FAIL val%0d got done=%b %b_%h want %b_%h", vals[i], done, overflow, bcd, exp_v[12], exp_v[11:0]); end
`ifdef BCD_BLANK_EN
            total++; if (digit_blank !== blank_model(exp_v)) begin bad++; $display("FAIL blank%0d got=%b want=%b", vals[i], digit_blank, blank_model(exp_v)); end
`endif
        end
    endtask

    task automatic test_ignore;
        int dones = 0;
        kick(8'd200);
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin binary = 8'd7; start = 1'b1; end
            if (i == 4) start = 1'b0;
            if (done) begin
                dones++;
                exp_v = q.size() > 0 ? q.pop_front() : 13'h1fff;
                total++; if ({overflow, bcd} !== exp_v) begin bad++; $display("FAIL ignore_val got=%b_%h want=%b_%h", overflow, bcd, exp_v[12], exp_v[11:0]); end
            end
            @(negedge clk);
        end
        total++; if (dones != 1) begin bad++; $display("FAIL ignore_dones got=%0d want=1", dones); end
    endtask

    task automatic test_back_to_back;
        int d1 = -1, d2 = -1;
        @(negedge clk);
        binary = 8'd42;
        start  = 1'b1;
        q.push_back(model(42));
        q.push_back(model(199));
        @(negedge clk);
        binary = 8'd199;
        for (int i = 1; i < 40 && d2 < 0; i++) begin
            if (d1 >= 0 && i == d1 + 1) start = 1'b0;
            if (done) begin
                if (d1 < 0) d1 = i; else d2 = i;
                exp_v = q.size() > 0 ? q.pop_front() : 13'h1fff;
                total++; if ({overflow, bcd} !== exp_v) begin bad++; $display("FAIL b2b_val got=%b_%h want=%b_%h", overflow, bcd, exp_v[12], exp_v[11:0]); end
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (d1 < 0 || d2 < 0 || d2 - d1 != 9) begin bad++; $display("FAIL b2b_gap got d1=%0d d2=%0d want gap=9", d1, d2); end
        repeat (12) @(negedge clk);
        q.delete();
    endtask

    task automatic test_wide;
        int vals[2] = '{999, 1000};
        int cyc;
        foreach (vals[i]) begin
            @(negedge clk);
            binary10 = 10'(vals[i]);
            start10  = 1'b1;
            exp_v    = model(vals[i]);
            @(negedge clk);
            start10 = 1'b0;
            cyc = 0;
            while (!done10 && cyc < 30) begin @(negedge clk); cyc++; end
            total++; if (done10 !== 1'b1 || cyc != 10 || {overflow10, bcd10} !== exp_v) begin bad++; $display("FAIL wide%0d got done=%b cyc=%0d %b_%h want cyc=10 %b_%h", vals[i], done10, cyc, overflow10, bcd10, exp_v[12], exp_v[11:0]); end
        end
    endtask

    task automatic test_reset_mid;
        int dones = 0, cyc, bc;
        kick(8'd77);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || overflow !== 1'b0) begin bad++; $display("FAIL mid_reset got busy=%b done=%b bcd=%h ovf=%b want 0 0 000 0", busy, done, bcd, overflow); end
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        total++; if (dones != 0) begin bad++; $display("FAIL mid_reset_dones got=%0d want=0", dones); end
        kick(8'd128);
        wait_done(cyc, bc);
        exp_v = q.pop_front();
        total++; if (done !== 1'b1 || {overflow, bcd} !== exp_v) begin bad++; $display("FAIL after_reset got done=%b %b_%h want %b_%h", done, overflow, bcd, exp_v[12], exp_v[11:0]); end
        kick(8'd7);
        wait_done(cyc, bc);
        exp_v = q.pop_front();
        total++; if (done !== 1'b1 || {overflow, bcd} !== exp_v) begin bad++; $display("FAIL val7 got done=%b %b_%h want %b_%h", done, overflow, bcd, exp_v[12], exp_v[11:0]); end
`ifdef BCD_BLANK_EN
        total++; if (digit_blank !== 3'b110) begin bad++; $display("FAIL blank7 got=%b want=110", digit_blank); end
`endif
    endtask

    initial begin
        #2;
        test_reset;
        test_basic;
        test_values;
        test_ignore;
        test_back_to_back;
        test_wide;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
